// File: rtl/div_mod_36_18_seq.sv
// Sequential radix-2 restoring divider: p = a*b + c with c < b.
// Inverse of the 18-bit multiply-add datapath. It uses a start/busy/done
// handshake, and all state is gated by ce.
module div_mod_36_18_seq #(
    parameter int WIDTH = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               start,
    input  logic [2*WIDTH-1:0] p,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   c,
    output logic               dz,
    output logic               ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    // The partial remainder stays below b, so its top bit is always zero
    // and only the low WIDTH bits are stored.
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b_reg;
    // An error result (divide-by-zero or overflow) is reported one enabled
    // edge after acceptance without entering RUN.
    logic             pend;
    logic             pend_dz;

    logic             accept;
    logic             b_zero;
    logic             too_big;
    logic             last_iter;
    logic             t_ge;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] t_sub;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign busy = (state == RUN);

    // Next-state logic plus the single restoring iteration step
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        b_zero     = (b == '0);
        too_big    = (p[2*WIDTH-1:WIDTH] >= b);
        t          = {r, q[WIDTH-1]};
        t_ge       = (t >= {1'b0, b_reg});
        t_sub      = t[WIDTH-1:0] - b_reg;
        r_next     = t_ge ? t_sub : t[WIDTH-1:0];
        q_next     = {q[WIDTH-2:0], t_ge};
        case (state)
            IDLE: begin
                if (start && !pend) begin
                    accept = 1'b1;
                    if (!b_zero && !too_big) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last_iter  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, frozen while ce is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    // Operand capture, iteration datapath and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            r       <= '0;
            q       <= '0;
            b_reg   <= '0;
            pend    <= 1'b0;
            pend_dz <= 1'b0;
            done    <= 1'b0;
            a       <= '0;
            c       <= '0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            if (accept) begin
                r       <= p[2*WIDTH-1:WIDTH];
                q       <= p[WIDTH-1:0];
                b_reg   <= b;
                cnt     <= '0;
                pend    <= b_zero || too_big;
                pend_dz <= b_zero;
            end else if (pend) begin
                pend <= 1'b0;
                done <= 1'b1;
                a    <= '1;
                c    <= pend_dz ? q : '0;
                dz   <= pend_dz;
                ovf  <= !pend_dz;
            end else if (state == RUN) begin
                r   <= r_next;
                q   <= q_next;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    cnt  <= '0;
                    a    <= q_next;
                    c    <= r_next;
                    dz   <= 1'b0;
                    ovf  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_mod_36_18_seq.sv
// Self-checking bench for div_mod_36_18_seq with a result scoreboard.
module tb_div_mod_36_18_seq;
    localparam int W = 18;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] c;
        logic         dz;
        logic         ovf;
    } exp_t;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           ce    = 1'b0;
    logic           start = 1'b0;
    logic [2*W-1:0] p     = '0;
    logic [W-1:0]   b     = '0;
    logic           busy;
    logic           done;
    logic [W-1:0]   a;
    logic [W-1:0]   c;
    logic           dz;
    logic           ovf;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    div_mod_36_18_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .start (start),
        .p     (p),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .a     (a),
        .c     (c),
        .dz    (dz),
        .ovf   (ovf)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference behaviour using plain integer division
    function automatic exp_t model(input logic [2*W-1:0] pv, input logic [W-1:0] bv);
        exp_t e;
        e = '0;
        if (bv == '0) begin
            e.a  = '1;
            e.c  = pv[W-1:0];
            e.dz = 1'b1;
        end else if (pv[2*W-1:W] >= bv) begin
            e.a   = '1;
            e.c   = '0;
            e.ovf = 1'b1;
        end else begin
            e.a = W'(pv / {{W{1'b0}}, bv});
            e.c = W'(pv % {{W{1'b0}}, bv});
        end
        return e;
    endfunction

    task automatic launch(input logic [2*W-1:0] pv, input logic [W-1:0] bv, input bit push);
        @(negedge clk);
        p     = pv;
        b     = bv;
        start = 1'b1;
        if (push) exp_q.push_back(model(pv, bv));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles, output int busy_cycles, output bit seen);
        cycles      = 0;
        busy_cycles = busy ? 1 : 0;
        seen        = done;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
            seen = done;
        end
    endtask

    task automatic pop_expected(output exp_t e, output bit ok);
        if (exp_q.size() == 0) begin
            e  = '0;
            ok = 1'b0;
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        ce    = 1'b1;
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({busy, done, a, c, dz, ovf} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b a=%h c=%h dz=%b ovf=%b, expected all 0",
                     busy, done, a, c, dz, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, a, c, dz, ovf} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b a=%h c=%h, expected all 0", busy, done, a, c);
        end
    endtask

    task automatic test_normal(input string name, input logic [2*W-1:0] pv, input logic [W-1:0] bv);
        int   cyc;
        int   bc;
        bit   seen;
        bit   have;
        exp_t e;
        launch(pv, bv, 1'b1);
        wait_done(40, cyc, bc, seen);
        pop_expected(e, have);
        tests_run++;
        if (!seen || cyc != 18 || bc != 18) begin
            tests_failed++;
            $display("[TB] FAIL %s_timing: got done=%b after %0d cycles busy %0d cycles, expected done after 18 busy 18",
                     name, seen, cyc, bc);
        end
        tests_run++;
        if (!have || {a, c, dz, ovf} !== e) begin
            tests_failed++;
            $display("[TB] FAIL %s_result: got a=%h c=%h dz=%b ovf=%b, expected a=%h c=%h dz=%b ovf=%b",
                     name, a, c, dz, ovf, e.a, e.c, e.dz, e.ovf);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || {a, c} !== {e.a, e.c}) begin
            tests_failed++;
            $display("[TB] FAIL %s_pulse: got done=%b a=%h c=%h, expected done=0 with results held",
                     name, done, a, c);
        end
    endtask

    task automatic test_errors();
        logic [2*W-1:0] pv [3];
        logic [W-1:0]   bv [3];
        int   cyc;
        int   bc;
        bit   seen;
        bit   have;
        exp_t e;
        pv[0] = 36'h123456789; bv[0] = 18'h0;
        pv[1] = 36'h000040000; bv[1] = 18'h1;
        pv[2] = 36'hFFFFC0005; bv[2] = 18'h3FFFF;
        for (int i = 0; i < 3; i++) begin
            launch(pv[i], bv[i], 1'b1);
            wait_done(10, cyc, bc, seen);
            pop_expected(e, have);
            tests_run++;
            if (!seen || cyc != 1 || bc != 0) begin
                tests_failed++;
                $display("[TB] FAIL error%0d_timing: got done=%b after %0d cycles busy %0d, expected done after 1 busy 0",
                         i, seen, cyc, bc);
            end
            tests_run++;
            if (!have || {a, c, dz, ovf} !== e) begin
                tests_failed++;
                $display("[TB] FAIL error%0d_result: got a=%h c=%h dz=%b ovf=%b, expected a=%h c=%h dz=%b ovf=%b",
                         i, a, c, dz, ovf, e.a, e.c, e.dz, e.ovf);
            end
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL error%0d_after: got done=%b busy=%b, expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0]   av;
        logic [W-1:0]   bv;
        logic [W-1:0]   cv;
        logic [2*W-1:0] pv;
        int   cyc;
        int   bc;
        bit   seen;
        bit   have;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 0) bv = W'($urandom_range(1, 255));
            else            bv = W'($urandom_range(1, (1 << W) - 1));
            av = W'($urandom);
            cv = W'($urandom % 32'(bv));
            pv = 36'(av) * 36'(bv) + 36'(cv);
            exp_q.push_back('{a: av, c: cv, dz: 1'b0, ovf: 1'b0});
            launch(pv, bv, 1'b0);
            wait_done(40, cyc, bc, seen);
            pop_expected(e, have);
            tests_run++;
            if (!seen || !have || {a, c, dz, ovf} !== e) begin
                tests_failed++;
                $display("[TB] FAIL random%0d: p=%h b=%h got done=%b a=%h c=%h dz=%b ovf=%b, expected a=%h c=%h",
                         i, pv, bv, seen, a, c, dz, ovf, e.a, e.c);
            end
        end
    endtask

    task automatic test_ce_stall();
        int   cyc;
        int   bc;
        int   extra;
        bit   seen;
        bit   have;
        exp_t e;
        launch(36'd123456789, 18'd1000, 1'b1);
        repeat (8) @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_frozen: got busy=%b done=%b, expected 1 0", busy, done);
        end
        start = 1'b1;
        p     = 36'h000000055;
        b     = 18'h0;
        repeat (2) @(negedge clk);
        ce = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(30, cyc, bc, seen);
        pop_expected(e, have);
        tests_run++;
        if (!seen || 15 + cyc != 23) begin
            tests_failed++;
            $display("[TB] FAIL stall_latency: got done=%b after %0d cycles, expected done after 23", seen, 15 + cyc);
        end
        tests_run++;
        if (!have || {a, c, dz, ovf} !== e) begin
            tests_failed++;
            $display("[TB] FAIL stall_result: got a=%h c=%h dz=%b ovf=%b, expected a=%h c=%h dz=%b ovf=%b",
                     a, c, dz, ovf, e.a, e.c, e.dz, e.ovf);
        end
        ce = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_done_hold: got done=%b, expected 1 while ce low", done);
        end
        ce = 1'b1;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_done_release: got done=%b, expected 0", done);
        end
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        tests_run++;
        if (extra != 0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_start_ignored: got %0d active cycles after completion, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        launch(36'd98765432, 18'd777, 1'b0);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, a, c, dz, ovf} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_clear: got busy=%b done=%b a=%h c=%h dz=%b ovf=%b, expected all 0",
                     busy, done, a, c, dz, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_no_done: got %0d done cycles, expected 0", extra);
        end
        test_normal("restart", 36'd98765432, 18'd777);
    endtask

    task automatic test_back_to_back(input int n);
        logic [2*W-1:0] pv;
        logic [W-1:0]   bv;
        exp_t prev;
        exp_t e;
        int   cyc;
        int   bc;
        bit   seen;
        bit   have;
        prev = '0;
        @(negedge clk);
        bv    = W'($urandom_range(1, (1 << W) - 1));
        pv    = 36'(W'($urandom)) * 36'(bv) + 36'($urandom % 32'(bv));
        p     = pv;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(model(pv, bv));
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                tests_run++;
                if ({a, c} !== {prev.a, prev.c}) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b%0d_hold: got a=%h c=%h, expected a=%h c=%h", k, a, c, prev.a, prev.c);
                end
            end
            wait_done(40, cyc, bc, seen);
            pop_expected(e, have);
            tests_run++;
            if (!seen || cyc + 1 != 19 || !have || {a, c, dz, ovf} !== e) begin
                tests_failed++;
                $display("[TB] FAIL b2b%0d: got done=%b interval=%0d a=%h c=%h, expected interval 19 a=%h c=%h",
                         k, seen, cyc + 1, a, c, e.a, e.c);
            end
            prev = e;
            if (k < n - 1) begin
                bv = W'($urandom_range(1, (1 << W) - 1));
                pv = 36'(W'($urandom)) * 36'(bv) + 36'($urandom % 32'(bv));
                p  = pv;
                b  = bv;
                exp_q.push_back(model(pv, bv));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_end: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_normal("basic", 36'd1000, 18'd7);
        test_normal("corner", 36'hFFFFBFFFF, 18'h3FFFF);
        test_errors();
        test_random(1500);
        test_ce_stall();
        test_reset_mid();
        test_back_to_back(6);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
